// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory address/data, decoder-side stall/redirect,
// and the IF/ID register contents handed to the decoder.
interface instr_fetch_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memData;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirectAddr;
    logic [DATA_W-1:0] instrOut;
    logic [ADDR_W-1:0] pcOut;
    logic              validOut;
    logic              halted;
    logic [CNT_W-1:0]  fetchCount;

    // Fetch stage side.
    modport master (
        output memAddr, instrOut, pcOut, validOut, halted, fetchCount,
        input  memData, stall, redirect, redirectAddr
    );

    // Memory/decoder side.
    modport slave (
        input  memAddr, instrOut, pcOut, validOut, halted, fetchCount,
        output memData, stall, redirect, redirectAddr
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instrMem combinationally and
// registers the fetched word/PC into IF/ID with stall, redirect and halt support.
module instr_fetch #(
    parameter int                ADDR_W    = 22,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int                CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_if.master       bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]  pcout_q, pcout_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Handshake: validOut marks a live IF/ID entry; while stall=1 the decoder
    // has not taken it, so IF/ID and PC hold. A cycle with validOut=1 and
    // stall=0 consumes the entry. redirect overrides stall and kills the entry.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcout_d  = pcout_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                if (bus.redirect) pc_d = bus.redirectAddr;
            end
            RUN: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirectAddr;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d = bus.memData;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
                    if (bus.memData == HALT_WORD) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            HALTED: begin
                if (bus.redirect) begin
                    pc_d     = bus.redirectAddr;
                    valid_d  = 1'b0;
                    halted_d = 1'b0;
                    state_d  = RUN;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pcout_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcout_q  <= pcout_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.memAddr    = pc_q;
    assign bus.instrOut   = instr_q;
    assign bus.pcOut      = pcout_q;
    assign bus.validOut   = valid_q;
    assign bus.halted     = halted_q;
    assign bus.fetchCount = cnt_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scripted directed cases plus random
// stall/redirect traffic, all compared every cycle against a behavioural model.
module tb_instr_fetch;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [DW-1:0] HALT = 32'hFFFF_FFFF;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] state_dbg;

    instr_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Instruction memory: mem[i] = 0x1000_0000 + i, with one optional halt word.
    logic          halt_en;
    logic [AW-1:0] halt_addr;
    assign bus.memData = (halt_en && bus.memAddr == halt_addr) ? HALT
                                                               : 32'h1000_0000 + {10'b0, bus.memAddr};

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    logic [AW-1:0] m_pc, m_pcout;
    logic [DW-1:0] m_instr;
    bit            m_valid, m_halted, m_bubble;
    int            m_cnt;

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (halt_en && a == halt_addr) ? HALT : 32'h1000_0000 + {10'b0, a};
    endfunction

    task automatic model_reset();
        m_pc = '0; m_pcout = '0; m_instr = '0;
        m_valid = 0; m_halted = 0; m_bubble = 1; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [DW-1:0] w;
        if (!reset) begin
            model_reset();
        end else if (m_bubble) begin
            if (bus.redirect) m_pc = bus.redirectAddr;
            m_bubble = 0;
        end else if (m_halted) begin
            if (bus.redirect) begin
                m_pc = bus.redirectAddr; m_valid = 0; m_halted = 0;
            end else if (!bus.stall) begin
                m_valid = 0;
            end
        end else if (bus.redirect) begin
            m_pc = bus.redirectAddr; m_valid = 0;
        end else if (!bus.stall) begin
            w = mem_model(m_pc);
            m_instr = w; m_pcout = m_pc; m_valid = 1;
            if (m_cnt < 65535) m_cnt++;
            if (w == HALT) m_halted = 1;
            else m_pc = m_pc + 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("memAddr",    64'(bus.memAddr),    64'(m_pc));
        check("validOut",   64'(bus.validOut),   64'(m_valid));
        check("halted",     64'(bus.halted),     64'(m_halted));
        check("fetchCount", 64'(bus.fetchCount), 64'(m_cnt));
        check("instrOut",   64'(bus.instrOut),   64'(m_instr));
        check("pcOut",      64'(bus.pcOut),      64'(m_pcout));
    endtask

    task automatic drive(input bit st, input bit rd, input logic [AW-1:0] ra);
        bus.stall = st; bus.redirect = rd; bus.redirectAddr = ra;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b0;
        halt_en = 1'b0; halt_addr = '0;
        drive(0, 0, '0);
        model_reset();
        repeat (2) cycle();
        check("rst_valid", 64'(bus.validOut), 64'd0);
        check("rst_memAddr", 64'(bus.memAddr), 64'd0);
        check("rst_count", 64'(bus.fetchCount), 64'd0);

        // Free run from reset
        reset = 1'b1;
        cycle();
        check("bubble_valid", 64'(bus.validOut), 64'd0);
        cycle();
        check("first_valid", 64'(bus.validOut), 64'd1);
        check("first_instr", 64'(bus.instrOut), 64'h1000_0000);
        check("first_pc", 64'(bus.pcOut), 64'd0);
        cycle(); cycle();
        check("pc2", 64'(bus.pcOut), 64'd2);

        // Stall while pcOut=2
        drive(1, 0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", 64'(bus.pcOut), 64'd2);
            check("stall_addr", 64'(bus.memAddr), 64'd3);
            check("stall_valid", 64'(bus.validOut), 64'd1);
        end
        drive(0, 0, '0);
        cycle();
        check("after_stall_pc", 64'(bus.pcOut), 64'd3);
        check("count4", 64'(bus.fetchCount), 64'd4);

        // Redirect wins over stall
        drive(1, 1, 22'h0000FF);
        cycle();
        check("redir_valid", 64'(bus.validOut), 64'd0);
        check("redir_addr", 64'(bus.memAddr), 64'hFF);
        drive(0, 0, '0);
        cycle();
        check("redir_pc", 64'(bus.pcOut), 64'hFF);
        check("redir_instr", 64'(bus.instrOut), 64'h1000_00FF);

        // Halt at address 5
        halt_en = 1'b1; halt_addr = 22'd5;
        drive(0, 1, 22'd3);
        cycle();
        drive(0, 0, '0);
        cycle(); cycle(); cycle();
        check("halt_pc", 64'(bus.pcOut), 64'd5);
        check("halt_flag", 64'(bus.halted), 64'd1);
        check("halt_valid", 64'(bus.validOut), 64'd1);
        cycle();
        check("halt_consumed", 64'(bus.validOut), 64'd0);
        check("halt_addr_frozen", 64'(bus.memAddr), 64'd5);
        cycle();
        drive(0, 1, 22'd0);
        cycle();
        check("unhalt", 64'(bus.halted), 64'd0);
        drive(0, 0, '0);
        cycle();
        check("resume_pc", 64'(bus.pcOut), 64'd0);
        check("resume_valid", 64'(bus.validOut), 64'd1);

        // PC wrap
        drive(0, 1, 22'h3FFFFF);
        cycle();
        drive(0, 0, '0);
        cycle();
        check("wrap_top", 64'(bus.pcOut), 64'h3FFFFF);
        cycle();
        check("wrap_zero", 64'(bus.pcOut), 64'd0);

        // Random traffic around a halt word and the top of the address space
        halt_addr = 22'h40;
        drive(0, 1, 22'h38);
        cycle();
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? AW'(22'h3FFFF8 + $urandom_range(0, 7))
                                             : AW'(22'h30 + $urandom_range(0, 31));
            drive($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8, ra);
            cycle();
        end

        // Async reset mid-run with fetchCount=7
        halt_en = 1'b0;
        drive(0, 0, '0);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        repeat (8) cycle();
        check("pre_reset_count", 64'(bus.fetchCount), 64'd7);
        check("pre_reset_valid", 64'(bus.validOut), 64'd1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_valid", 64'(bus.validOut), 64'd0);
        check("async_count", 64'(bus.fetchCount), 64'd0);
        check("async_pc", 64'(bus.pcOut), 64'd0);
        check("async_instr", 64'(bus.instrOut), 64'd0);
        check("async_addr", 64'(bus.memAddr), 64'd0);
        cycle();
        reset = 1'b1;
        cycle();
        check("rebubble_valid", 64'(bus.validOut), 64'd0);
        cycle();
        check("rerun_pc", 64'(bus.pcOut), 64'd0);
        check("rerun_valid", 64'(bus.validOut), 64'd1);

        // Counter saturation
        for (int i = 0; i < 70000 && m_cnt < 65535; i++) cycle();
        repeat (3) cycle();
        check("count_sat", 64'(bus.fetchCount), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
